// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared microwave control types and timing constants
package microwave_pkg;

    // Button event classifier FSM states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } btn_state_t;

    // Clock cycles per 1 ms tick at 100 MHz; also used by the cook timer
    localparam int TICK_1MS_CYCLES = 100_000;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running tick prescaler with synchronous clear
module tick_gen
    import microwave_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_1MS_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Count 0..TICK_CYCLES-1; clr restarts the period so the next tick is a full period away
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = !clr && (r_cnt == LAST);

endmodule

// File: rtl/btn_event_classifier.sv
// rtl/btn_event_classifier.sv - debounced button level to press/short/long/repeat pulses
module btn_event_classifier
    import microwave_pkg::*;
#(
    parameter int TICK_CYCLES  = TICK_1MS_CYCLES,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press,
    output logic o_short,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);

    btn_state_t    r_state, w_state_nxt;
    logic          r_btn_d;
    logic [HW-1:0] r_hold_cnt, w_hold_nxt;
    logic [RW-1:0] r_rep_cnt, w_rep_nxt;
    logic          r_press, r_short, r_long, r_repeat, r_held;
    logic          w_press_nxt, w_short_nxt, w_long_nxt, w_repeat_nxt;
    logic          w_press_edge, w_release_edge, w_tick;

    assign w_press_edge   = i_btn && !r_btn_d;
    assign w_release_edge = !i_btn && r_btn_d;

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (w_press_edge),
        .tick(w_tick)
    );

    // State, counters, edge history and registered pulse outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_btn_d    <= 1'b1;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_press    <= 1'b0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
            r_held     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_btn_d    <= i_btn;
            r_hold_cnt <= w_hold_nxt;
            r_rep_cnt  <= w_rep_nxt;
            r_press    <= w_press_nxt;
            r_short    <= w_short_nxt;
            r_long     <= w_long_nxt;
            r_repeat   <= w_repeat_nxt;
            r_held     <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state and pulse decode; release is checked before ticks so it wins any race
    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold_cnt;
        w_rep_nxt    = r_rep_cnt;
        w_press_nxt  = 1'b0;
        w_short_nxt  = 1'b0;
        w_long_nxt   = 1'b0;
        w_repeat_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press_edge) begin
                    w_press_nxt = 1'b1;
                    w_hold_nxt  = '0;
                    w_state_nxt = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (w_release_edge) begin
                    w_short_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_long_nxt  = 1'b1;
                        w_rep_nxt   = '0;
                        w_state_nxt = ST_LONG_HELD;
                    end
                end
            end
            ST_LONG_HELD: begin
                if (w_release_edge) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    if (r_rep_cnt == REP_LAST) begin
                        w_repeat_nxt = 1'b1;
                        w_rep_nxt    = '0;
                    end else begin
                        w_rep_nxt = r_rep_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_press  = r_press;
    assign o_short  = r_short;
    assign o_long   = r_long;
    assign o_repeat = r_repeat;
    assign o_held   = r_held;

endmodule

// File: tb/tb_btn_event_classifier.sv
// tb/tb_btn_event_classifier.sv - self-checking bench for btn_event_classifier
module tb_btn_event_classifier;

    localparam int T = 10;
    localparam int L = 5;
    localparam int R = 2;
    localparam int K_PRESS  = 0;
    localparam int K_SHORT  = 1;
    localparam int K_LONG   = 2;
    localparam int K_REPEAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic drv_btn = 1'b0;
    logic use_deb = 1'b0;
    logic raw_btn = 1'b0;
    logic r_deb = 1'b0;
    logic r_raw_last = 1'b0;
    int   r_stable = 0;
    wire  i_btn = use_deb ? r_deb : drv_btn;
    logic o_press, o_short, o_long, o_repeat, o_held;

    typedef struct {
        int cyc;
        int kind;
    } exp_t;

    typedef struct {
        int hold;
        bit exp_short;
        bit exp_long;
        int exp_repeats;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_press = 0;
    int   n_short = 0;
    bit   sb_off = 1'b0;

    always #5 clk = ~clk;

    btn_event_classifier #(
        .TICK_CYCLES (T),
        .LONG_TICKS  (L),
        .REPEAT_TICKS(R)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (i_btn),
        .o_press (o_press),
        .o_short (o_short),
        .o_long  (o_long),
        .o_repeat(o_repeat),
        .o_held  (o_held)
    );

    // Stand-in upstream debouncer: follows raw_btn once it has been stable for 4 cycles
    always @(posedge clk) begin
        if (raw_btn == r_raw_last) begin
            r_stable <= r_stable + 1;
            if (r_stable >= 3) r_deb <= raw_btn;
        end else begin
            r_stable <= 0;
        end
        r_raw_last <= raw_btn;
    end

    initial begin
        #200us;
        $display("FAIL timeout: bench did not finish within 200 us");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int k);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        sbq.push_back(e);
    endtask

    // Sample outputs of the current cycle at the falling edge and match against the scoreboard
    task automatic monitor();
        logic [3:0] p;
        p = {o_repeat, o_long, o_short, o_press};
        if (o_press) n_press++;
        if (o_short) n_short++;
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed pulse kind=%0d: got none expected at cycle %0d (now %0d)",
                     sbq[0].kind, sbq[0].cyc, cyc);
            void'(sbq.pop_front());
        end
        if (p != 4'b0) begin
            checks++;
            if ($countones(p) > 1) begin
                errors++;
                $display("FAIL exclusive: got pulses %b expected at most one high (cycle %0d)", p, cyc);
            end
        end
        if (!sb_off) begin
            for (int k = 0; k < 4; k++) begin
                if (p[k]) begin
                    checks++;
                    if (sbq.size() > 0 && sbq[0].cyc == cyc && sbq[0].kind == k) begin
                        void'(sbq.pop_front());
                    end else begin
                        errors++;
                        $display("FAIL pulse kind=%0d: got pulse at cycle %0d expected none", k, cyc);
                    end
                end
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            #2;
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int c;
        c = cyc;
        drv_btn = 1'b1;
        push(c + 1, K_PRESS);
        if (v.exp_long) begin
            push(c + 1 + T * L, K_LONG);
            for (int k = 1; k <= v.exp_repeats; k++) push(c + 1 + T * L + k * T * R, K_REPEAT);
        end
        if (v.exp_short) push(c + v.hold + 1, K_SHORT);
        step(v.hold);
        check($sformatf("held_during_%0d", v.hold), o_held, 1);
        drv_btn = 1'b0;
        step(1);
        check($sformatf("held_after_%0d", v.hold), o_held, 0);
        step(30);
        check($sformatf("sb_drained_%0d", v.hold), sbq.size(), 0);
    endtask

    initial begin
        int c;
        int p0;
        int s0;
        vec_t v;

        // hold cycles, short, long, repeats
        v = '{20, 1, 0, 0};  vecs.push_back(v);
        v = '{100, 0, 1, 2}; vecs.push_back(v);
        v = '{50, 1, 0, 0};  vecs.push_back(v);
        v = '{51, 0, 1, 0};  vecs.push_back(v);
        v = '{70, 0, 1, 0};  vecs.push_back(v);
        v = '{71, 0, 1, 1};  vecs.push_back(v);
        v = '{1, 1, 0, 0};   vecs.push_back(v);

        #1 rst = 1'b0;
        @(posedge clk);
        #2;
        check("rst_press", o_press, 0);
        check("rst_short", o_short, 0);
        check("rst_long", o_long, 0);
        check("rst_repeat", o_repeat, 0);
        check("rst_held", o_held, 0);
        step(3);
        rst = 1'b1;
        step(3);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back clicks: 100 ns high, 20 ns low, 100 ns high
        c = cyc;
        drv_btn = 1'b1;
        push(c + 1, K_PRESS);
        push(c + 11, K_SHORT);
        push(c + 13, K_PRESS);
        push(c + 23, K_SHORT);
        step(10);
        drv_btn = 1'b0;
        step(2);
        drv_btn = 1'b1;
        step(10);
        drv_btn = 1'b0;
        step(20);
        check("b2b_drained", sbq.size(), 0);

        // Reset in the middle of a hold, button stays down afterwards
        c = cyc;
        drv_btn = 1'b1;
        push(c + 1, K_PRESS);
        step(30);
        rst = 1'b0;
        #1;
        check("midrst_press", o_press, 0);
        check("midrst_long", o_long, 0);
        check("midrst_held", o_held, 0);
        step(3);
        rst = 1'b1;
        step(80);
        check("postrst_held", o_held, 0);
        check("postrst_drained", sbq.size(), 0);
        drv_btn = 1'b0;
        step(5);
        c = cyc;
        drv_btn = 1'b1;
        push(c + 1, K_PRESS);
        push(c + 11, K_SHORT);
        step(10);
        drv_btn = 1'b0;
        step(10);
        check("repress_drained", sbq.size(), 0);

        // Upstream chain: bouncy raw input through a debouncer
        sb_off = 1'b1;
        use_deb = 1'b1;
        p0 = n_press;
        s0 = n_short;
        for (int b = 0; b < 2; b++) begin
            raw_btn = 1'b1; step(1);
            raw_btn = 1'b0; step(1);
            raw_btn = 1'b1; step(20);
            raw_btn = 1'b0; step(1);
            raw_btn = 1'b1; step(1);
            raw_btn = 1'b0; step(20);
        end
        check("chain_presses", n_press - p0, 2);
        check("chain_shorts", n_short - s0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
